// File: rtl/servo_pwm_gen.sv
// Multi-channel hobby-servo PWM generator with shadowed pulse-width registers.
// New widths take effect only at a period boundary, so a pulse is never cut short.
module servo_pwm_gen #(
   parameter int NUM_CH    = 12,
   parameter int CLK_DIV   = 100,
   parameter int PERIOD_US = 20000,
   parameter int PW_W      = 16,
   parameter int PW_MIN    = 500,
   parameter int PW_MAX    = 2500
) (
   input  logic                      s_axi_aclk,
   input  logic                      s_axi_aresetn,
   input  logic                      enable,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [$clog2(NUM_CH)-1:0] wr_ch,
   input  logic [PW_W-1:0]           wr_pw,
   output logic                      wr_err,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic                      period_start,
   output logic [15:0]               frame_cnt
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int US_W  = $clog2(PERIOD_US);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [US_W-1:0]  US_LAST  = US_W'(PERIOD_US - 1);
   localparam logic [PW_W-1:0]  PW_MIN_V = PW_W'(PW_MIN);
   localparam logic [PW_W-1:0]  PW_MAX_V = PW_W'(PW_MAX);

   logic [PRE_W-1:0]  prescaler;
   logic [US_W-1:0]   us_cnt;
   logic [PW_W-1:0]   shadow [NUM_CH];
   logic [PW_W-1:0]   active [NUM_CH];
   logic              enable_active;
   logic              tick;
   logic              boundary;
   logic              wr_fire;
   logic              ch_ok;
   logic [PW_W-1:0]   pw_clamped;
   logic [NUM_CH-1:0] pwm_next;

   // Writes are held off during the boundary cycle so shadow->active never races a write.
   always_comb begin
      tick     = (prescaler == PRE_LAST);
      boundary = tick && (us_cnt == US_LAST);
      wr_ready = !boundary;
      wr_fire  = wr_valid && wr_ready;
      ch_ok    = int'(wr_ch) < NUM_CH;
   end

   // NOTE: every variable in an always_comb gets a value on every path (here the
   // if/else chain is complete); a missing branch would infer a latch.
   always_comb begin
      if (wr_pw == '0) begin
         pw_clamped = '0;
      end else if (wr_pw < PW_MIN_V) begin
         pw_clamped = PW_MIN_V;
      end else if (wr_pw > PW_MAX_V) begin
         pw_clamped = PW_MAX_V;
      end else begin
         pw_clamped = wr_pw;
      end
   end

   always_comb begin
      pwm_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pwm_next[i] = enable_active && (active[i] != '0) && (int'(us_cnt) < int'(active[i]));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         prescaler    <= '0;
         us_cnt       <= '0;
         period_start <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         prescaler    <= tick ? '0 : prescaler + 1'b1;
         period_start <= boundary;
         if (boundary) begin
            us_cnt    <= '0;
            frame_cnt <= frame_cnt + 16'd1;
         end else if (tick) begin
            us_cnt <= us_cnt + 1'b1;
         end
      end
   end

   // NOTE: the shadow and active arrays are reset on purpose: after reset every
   // channel must read as off until software writes it again.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         enable_active <= 1'b0;
         wr_err        <= 1'b0;
      end else begin
         wr_err <= wr_fire && !ch_ok;
         if (wr_fire && ch_ok) begin
            shadow[wr_ch] <= pw_clamped;
         end
         if (boundary) begin
            for (int i = 0; i < NUM_CH; i++) begin
               active[i] <= shadow[i];
            end
            enable_active <= enable;
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         pwm_out <= '0;
      end else begin
         pwm_out <= pwm_next;
      end
   end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: per-period pulse widths and frame numbers are queued
// by the stimulus and compared by a monitor that closes each period window.
module tb_servo_pwm_gen;

   localparam int NUM_CH     = 4;
   localparam int CLK_DIV    = 4;
   localparam int PERIOD_US  = 50;
   localparam int PW_W       = 16;
   localparam int PW_MIN     = 5;
   localparam int PW_MAX     = 40;
   localparam int PERIOD_CLK = CLK_DIV * PERIOD_US;

   typedef struct packed {
      logic [15:0]              frame;
      logic [NUM_CH-1:0][15:0]  hi;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              enable;
   logic              wr_valid;
   logic              wr_valid3;
   logic [1:0]        wr_ch;
   logic [PW_W-1:0]   wr_pw;
   logic              wr_ready, wr_err, period_start;
   logic [NUM_CH-1:0] pwm_out;
   logic [15:0]       frame_cnt;
   logic              wr_ready3, wr_err3, period_start3;
   logic [2:0]        pwm_out3;
   logic [15:0]       frame_cnt3;

   servo_pwm_gen #(
      .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US),
      .PW_W(PW_W), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
   ) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .enable(enable),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_pw(wr_pw),
      .wr_err(wr_err), .pwm_out(pwm_out), .period_start(period_start),
      .frame_cnt(frame_cnt)
   );

   // Three-channel instance so that index 3 is out of range.
   servo_pwm_gen #(
      .NUM_CH(3), .CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US),
      .PW_W(PW_W), .PW_MIN(PW_MIN), .PW_MAX(PW_MAX)
   ) dut3 (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .enable(enable),
      .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_ch(wr_ch), .wr_pw(wr_pw),
      .wr_err(wr_err3), .pwm_out(pwm_out3), .period_start(period_start3),
      .frame_cnt(frame_cnt3)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input int f, input int h0, input int h1, input int h2, input int h3);
      exp_t e;
      e.frame = 16'(f);
      e.hi[0] = 16'(h0);
      e.hi[1] = 16'(h1);
      e.hi[2] = 16'(h2);
      e.hi[3] = 16'(h3);
      exp_q.push_back(e);
   endtask

   // Monitor: a window runs from one period_start sample to the next.
   int          k;
   logic [15:0] win_frame;
   int          hi    [NUM_CH];
   int          first [NUM_CH];
   bit          win_open = 1'b0;
   int          err_main = 0;
   int          err3_cnt = 0;
   int          hi3      = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         win_open = 1'b0;
      end else begin
         if (wr_err === 1'b1) err_main++;
         if (wr_err3 === 1'b1) err3_cnt++;
         if (pwm_out3 !== 3'b000) hi3++;
         if (period_start) begin
            if (win_open) begin
               check("scoreboard_nonempty", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("frame_cnt", 32'(win_frame), 32'(e.frame));
                  check("period_len", 32'(k), PERIOD_CLK);
                  for (int i = 0; i < NUM_CH; i++) begin
                     check($sformatf("f%0d_hi_ch%0d", e.frame, i), 32'(hi[i]), 32'(e.hi[i]));
                     if (e.hi[i] != 0)
                        check($sformatf("f%0d_rise_ch%0d", e.frame, i), 32'(first[i]), 1);
                  end
               end
            end
            win_open  = 1'b1;
            win_frame = frame_cnt;
            k         = 0;
            for (int i = 0; i < NUM_CH; i++) begin
               hi[i]    = 0;
               first[i] = -1;
            end
         end
         if (win_open) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (pwm_out[i] === 1'b1) begin
                  hi[i]++;
                  if (first[i] < 0) first[i] = k;
               end
            end
            k++;
         end
      end
   end

   task automatic wait_ps();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 2 * PERIOD_CLK);
      check("period_start_seen", 32'(period_start), 1);
   endtask

   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic do_write(input bit sel3, input int ch, input int pw);
      int n = 0;
      wr_ch = 2'(ch);
      wr_pw = PW_W'(pw);
      if (sel3) wr_valid3 = 1'b1;
      else      wr_valid  = 1'b1;
      while (!(sel3 ? wr_ready3 : wr_ready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wr_accept", 32'(sel3 ? wr_ready3 : wr_ready), 1);
      @(negedge clk);
      wr_valid  = 1'b0;
      wr_valid3 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_valid3 = 1'b0;
      wr_ch = '0; wr_pw = '0;
      #23;
      check("rst_pwm_out", 32'(pwm_out), 0);
      check("rst_period_start", 32'(period_start), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      check("rst_wr_err", 32'(wr_err), 0);
      check("rst_wr_ready", 32'(wr_ready), 1);
      @(negedge clk); #1 rst_n = 1'b1;

      // Idle periods, then ch0 = 10 written mid-period.
      wait_ps(); push_exp(1, 0, 0, 0, 0);
      wait_ps(); push_exp(2, 0, 0, 0, 0);
      skip(50); do_write(0, 0, 10);
      wait_ps(); push_exp(3, 40, 0, 0, 0);
      skip(30); do_write(0, 1, 2); do_write(0, 2, 100);
      wait_ps(); push_exp(4, 40, 20, 160, 0);
      skip(30); do_write(0, 2, 0);

      // Write held across the boundary cycle.
      wait_ps(); push_exp(5, 40, 20, 0, 0);
      skip(PERIOD_CLK - 1);
      wr_ch = 2'd3; wr_pw = 16'd30; wr_valid = 1'b1;
      check("wr_ready_boundary", 32'(wr_ready), 0);
      @(negedge clk);
      check("boundary_align", 32'(period_start), 1);
      check("wr_ready_after", 32'(wr_ready), 1);
      push_exp(6, 40, 20, 0, 0);
      @(negedge clk); wr_valid = 1'b0;

      // Valid index 3 on the 4-channel part, invalid index 3 on the 3-channel part.
      wait_ps(); push_exp(7, 40, 20, 0, 120);
      skip(40);
      do_write(0, 3, 25);
      check("wr_err_valid_ch", 32'(wr_err), 0);
      do_write(1, 3, 30);
      check("wr_err3_pulse", 32'(wr_err3), 1);
      @(negedge clk);
      check("wr_err3_one_cycle", 32'(wr_err3), 0);

      // Enable dropped mid-pulse, then restored.
      wait_ps(); push_exp(8, 40, 20, 0, 100);
      skip(13); enable = 1'b0;
      wait_ps(); push_exp(9, 0, 0, 0, 0);
      skip(50); enable = 1'b1;

      // Asynchronous reset in the middle of the pulses.
      wait_ps();
      skip(20);
      check("pre_reset_pwm", 32'(pwm_out), 32'b1011);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_pwm", 32'(pwm_out), 0);
      check("async_rst_frame", 32'(frame_cnt), 0);
      check("async_rst_ready", 32'(wr_ready), 1);
      skip(2); #1 rst_n = 1'b1;

      // Channels stay off until rewritten.
      wait_ps(); push_exp(1, 0, 0, 0, 0);
      wait_ps(); push_exp(2, 0, 0, 0, 0);
      skip(60); do_write(0, 0, 10);
      wait_ps(); push_exp(3, 40, 0, 0, 0);
      wait_ps();
      @(negedge clk);

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      check("wr_err_main_cycles", 32'(err_main), 0);
      check("wr_err3_cycles", 32'(err3_cnt), 1);
      check("dut3_pwm_high_cycles", 32'(hi3), 0);
      check("dut3_frame_sync", 32'(frame_cnt3), 32'(frame_cnt));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
